// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequencer for the AES-128 round datapath.
// Accepts a block start, then walks rounds 0..NR: fetch the round key,
// pulse ok_row, wait for ok_col. Flags rounds 0 and NR so mixcol is
// bypassed there, and reports done, or err if ok_col never arrives.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start, ready   block request (sampled in IDLE) / idle indicator
//   ld_state       1-cycle pulse: load plaintext into the state register
//   key_req/ack    round key handshake for index `round`
//   round          current round index 0..NR
//   is_first/final round 0 / round NR while busy
//   ok_row, ok_col round issue pulse / datapath round result valid
//   done, err      1-cycle completion / timeout-abort pulses
// All outputs are registered. They are computed from next-state values,
// so each one equals a Moore decode of the current state.
module aes_round_ctrl #(
  parameter int unsigned NR      = 10,
  parameter int unsigned RW      = 4,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TW      = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          ready,
  output logic          ld_state,
  output logic          key_req,
  input  logic          key_ack,
  output logic [RW-1:0] round,
  output logic          is_first,
  output logic          is_final,
  output logic          ok_row,
  input  logic          ok_col,
  output logic          done,
  output logic          err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_KEY   = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  localparam logic [RW-1:0] LAST_ROUND = RW'(NR);
  localparam logic [TW-1:0] LAST_TICK  = TW'(TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [RW-1:0] round_q, round_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          busy_d;

  // Next-state, round index and wait timer.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          round_d = '0;
        end
      end
      S_LOAD:  state_d = S_KEY;
      S_KEY: begin
        if (key_ack) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        timer_d = '0;
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        // ok_col takes priority over a coincident timeout.
        if (ok_col) begin
          if (round_q == LAST_ROUND) begin
            state_d = S_DONE;
          end else begin
            round_d = round_q + RW'(1);
            state_d = S_KEY;
          end
        end else if (timer_q == LAST_TICK) begin
          state_d = S_ERR;
        end
      end
      S_DONE, S_ERR: begin
        state_d = S_IDLE;
        round_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        round_d = '0;
      end
    endcase
  end

  assign busy_d = (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERR);

  // State registers and registered output decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      round_q  <= '0;
      timer_q  <= '0;
      ready    <= 1'b1;
      ld_state <= 1'b0;
      key_req  <= 1'b0;
      is_first <= 1'b0;
      is_final <= 1'b0;
      ok_row   <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      timer_q  <= timer_d;
      ready    <= (state_d == S_IDLE);
      ld_state <= (state_d == S_LOAD);
      key_req  <= (state_d == S_KEY);
      is_first <= busy_d && (round_d == '0);
      is_final <= busy_d && (round_d == LAST_ROUND);
      ok_row   <= (state_d == S_ISSUE);
      done     <= (state_d == S_DONE);
      err      <= (state_d == S_ERR);
    end
  end

  assign round = round_q;

endmodule
